ccu_arb: RTL
============

Name: ccu_arb

Overview:
Arbitrates CCU-side requesters (I-cache fill, D-cache fill, D-cache victim writeback, ...) for the single Wishbone BIU port.
- Round-robin grant; the grant is held for one whole cacheline transaction.
- Latches the winner's command.
- Drives the BIU en/we/addr/data handshake.
- Returns read data and a one-cycle done pulse to the granted requester.
- Sits between the cache controllers and the BIU, in the core clock domain.

Parameters:
- CCU_ARB_DEPTH, 2: number of requesters. Must be ≥2.
- CCU_ARB_IDX_WIDTH, $clog2(CCU_ARB_DEPTH): grant index width.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  reset. Synchronous, active-high.
- i_req_en  in  CCU_ARB_DEPTH  per-requester request valid; held high until that requester's done.
- i_req_we  in  CCU_ARB_DEPTH  per-requester write (1) / read (0).
- i_req_addr  in  CCU_ARB_DEPTH x procyon_addr_t  line-aligned address per requester.
- i_req_data  in  CCU_ARB_DEPTH x procyon_cacheline_t  write line per requester.
- o_req_done  out  CCU_ARB_DEPTH  one-hot, one-cycle completion pulse.
- o_req_data  out  procyon_cacheline_t  read line, shared by all requesters; qualified by o_req_done.
- o_biu_en  out  1  BIU transaction enable.
- o_biu_we  out  1  BIU write enable.
- o_biu_addr  out  procyon_addr_t  BIU address.
- o_biu_data  out  procyon_cacheline_t  BIU write line.
- i_biu_data  in  procyon_cacheline_t  BIU read line.
- i_biu_busy  in  1  BIU in REQS/ACKS; used by assertions only.
- i_biu_done  in  1  BIU transaction complete; held while o_biu_en stays high.

Behaviour:
- States:
  - IDLE: no grant.
  - BUSY: transaction issued to the BIU.
  - DRAIN: en dropped, BIU returning to its IDLE.
  All outputs are registered from state/latches.
- Reset (i_rst high at a clock edge) clears:
  - state to IDLE; rr_ptr to 0; grant_idx to 0;
  - o_biu_en, o_biu_we, o_req_done to 0; o_biu_addr, o_biu_data, o_req_data to 0.
  - Reset mid-transaction abandons the transaction with no done pulse. The BIU must be reset together with the arbiter.
- IDLE:
  - If |i_req_en, pick the winner with the round-robin picker: first set bit at or after rr_ptr, wrapping modulo CCU_ARB_DEPTH.
  - Latch grant_idx, we, addr and data of the winner, then go to BUSY.
  - If no request, stay in IDLE.
- BUSY:
  - o_biu_en=1; o_biu_we/addr/data come from the latches.
  - Requester inputs are ignored after latching; the requester may change addr/data, but en must stay high.
  - When i_biu_done=1: capture i_biu_data into o_req_data (reads only; writes leave o_req_data unchanged), set rr_ptr=grant_idx+1 (wrap to 0 at CCU_ARB_DEPTH), go to DRAIN.
- DRAIN (exactly 1 cycle):
  - o_biu_en=0; o_req_done[grant_idx]=1; go to IDLE.
  - The BIU sees en low in its DONE state and is idle on the next cycle, so the next grant is never issued while the BIU is in DONE.
- Requester contract:
  - Deassert i_req_en in the cycle after the o_req_done pulse.
  - An en still high in the IDLE cycle after DRAIN is a new request. Because rr_ptr has advanced, other pending requesters win first.
- Latency:
  - Request seen in IDLE at cycle t: o_biu_en rises at t+1.
  - i_biu_done at cycle d: o_biu_en falls and o_req_done pulses at d+1; next grant decided at d+2; next o_biu_en at d+3.
- Simultaneous requests: exactly one grant, by round-robin. No requester starves: with all requesters asserted, the grant rotates 0,1,...,N-1,0.
- A requester dropping i_req_en while granted is a protocol violation (asserted); the transaction still completes.
- Assertions:
  - o_req_done is one-hot or zero.
  - o_biu_en is never high in IDLE/DRAIN.
  - i_biu_done is never high outside BUSY.

Decomposition:
- Package (procyon_types): ccu_arb_state_t enum {IDLE, BUSY, DRAIN}; ccu_arb_idx_t; constant CCU_ARB_DEPTH default.
- Sub-module rr_picker: combinational round-robin select. Inputs: request vector, pointer. Outputs: valid, index. Parameterised by CCU_ARB_DEPTH.

Test Plan:
1. Single read: req0 en, we=0, addr=0x1000; BIU returns line 0xA5.. 3 cycles after en → o_biu_en=1 one cycle after request; o_req_done=2'b01 exactly 1 cycle after i_biu_done, with o_req_data=0xA5..; o_biu_en=0 in that same cycle.
2. Single write: req1 en, we=1, addr=0x2040, data=0xDEAD.. → o_biu_we=1, o_biu_addr=0x2040, o_biu_data=0xDEAD.. for the whole BUSY; o_req_done=2'b10; o_req_data unchanged.
3. Contention: req0 and req1 both asserted from reset and re-asserted after each done → grants alternate 0,1,0,1; no back-to-back grant to the same index while the other is pending.
4. Back-to-back spacing: two queued requests → o_biu_en low for exactly 2 cycles between transactions; the BIU is never in DONE while o_biu_en=1 for the new grant.
5. Input change after grant: req0 changes addr 0x1000→0x3000 during BUSY → o_biu_addr stays 0x1000.
6. Reset mid-transaction: assert i_rst during BUSY → next cycle state=IDLE, o_biu_en=0, o_req_done=0, rr_ptr=0; a later req1 is served normally.

Source files
------------

// File: rtl/procyon_types.sv
// Shared types for the CCU-to-BIU arbitration path: address and cacheline
// containers, arbiter state encoding and default requester count.
package procyon_types;

    localparam int PROCYON_ADDR_WIDTH      = 32;
    localparam int PROCYON_CACHELINE_WIDTH = 128;

    localparam int CCU_ARB_DEPTH_DFLT     = 2;
    localparam int CCU_ARB_IDX_WIDTH_DFLT = $clog2(CCU_ARB_DEPTH_DFLT);

    typedef logic [PROCYON_ADDR_WIDTH-1:0]      procyon_addr_t;
    typedef logic [PROCYON_CACHELINE_WIDTH-1:0] procyon_cacheline_t;
    typedef logic [CCU_ARB_IDX_WIDTH_DFLT-1:0]  ccu_arb_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10
    } ccu_arb_state_t;

endpackage

// File: rtl/ccu_arb_chk.sv
// Protocol checker for ccu_arb: grant/handshake invariants between the
// arbiter, its requesters and the BIU.
module ccu_arb_chk
    import procyon_types::*;
#(
    parameter int CCU_ARB_DEPTH     = 2,
    parameter int CCU_ARB_IDX_WIDTH = $clog2(CCU_ARB_DEPTH)
) (
    input logic                         i_clk,
    input logic                         i_rst,
    input ccu_arb_state_t               i_state,
    input logic [CCU_ARB_IDX_WIDTH-1:0] i_grant_idx,
    input logic [CCU_ARB_DEPTH-1:0]     i_req_en,
    input logic [CCU_ARB_DEPTH-1:0]     i_req_done,
    input logic                         i_biu_en,
    input logic                         i_biu_busy,
    input logic                         i_biu_done
);

    a_done_onehot0: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(i_req_done));

    a_en_only_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        i_biu_en |-> (i_state == BUSY));

    a_biu_done_only_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        i_biu_done |-> (i_state == BUSY));

    a_biu_busy_only_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        i_biu_busy |-> (i_state == BUSY));

    a_grant_en_held: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_state == BUSY) |-> i_req_en[i_grant_idx]);

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request bit at or after the
// pointer, wrapping around the requester count.
module rr_picker #(
    parameter int CCU_ARB_DEPTH     = 2,
    parameter int CCU_ARB_IDX_WIDTH = $clog2(CCU_ARB_DEPTH)
) (
    input  logic [CCU_ARB_DEPTH-1:0]     i_req,
    input  logic [CCU_ARB_IDX_WIDTH-1:0] i_ptr,
    output logic                         o_valid,
    output logic [CCU_ARB_IDX_WIDTH-1:0] o_idx
);

    // Requester index at a given offset from the pointer, modulo the depth.
    function automatic logic [CCU_ARB_IDX_WIDTH-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= CCU_ARB_DEPTH) begin
            sum = sum - CCU_ARB_DEPTH;
        end else begin
            sum = sum;
        end
        return CCU_ARB_IDX_WIDTH'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = {CCU_ARB_IDX_WIDTH{1'b0}};
        for (int i = CCU_ARB_DEPTH - 1; i >= 0; i--) begin
            o_valid = o_valid | i_req[wrap_idx(int'(i_ptr), i)];
            o_idx   = i_req[wrap_idx(int'(i_ptr), i)] ? wrap_idx(int'(i_ptr), i) : o_idx;
        end
    end

endmodule

// File: rtl/ccu_arb.sv
// Round-robin arbiter granting one cache requester at a time access to the
// single Wishbone BIU port for a whole cacheline transaction.
module ccu_arb
    import procyon_types::*;
#(
    parameter int CCU_ARB_DEPTH     = CCU_ARB_DEPTH_DFLT,
    parameter int CCU_ARB_IDX_WIDTH = $clog2(CCU_ARB_DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [CCU_ARB_DEPTH-1:0] i_req_en,
    input  logic [CCU_ARB_DEPTH-1:0] i_req_we,
    input  procyon_addr_t            i_req_addr [CCU_ARB_DEPTH],
    input  procyon_cacheline_t       i_req_data [CCU_ARB_DEPTH],
    output logic [CCU_ARB_DEPTH-1:0] o_req_done,
    output procyon_cacheline_t       o_req_data,
    output logic                     o_biu_en,
    output logic                     o_biu_we,
    output procyon_addr_t            o_biu_addr,
    output procyon_cacheline_t       o_biu_data,
    input  procyon_cacheline_t       i_biu_data,
    input  logic                     i_biu_busy,
    input  logic                     i_biu_done
);

    ccu_arb_state_t                 r_state;
    ccu_arb_state_t                 w_state_next;
    logic [CCU_ARB_IDX_WIDTH-1:0]   r_rr_ptr;
    logic [CCU_ARB_IDX_WIDTH-1:0]   r_grant_idx;
    logic [CCU_ARB_IDX_WIDTH-1:0]   w_ptr_next;
    logic                           w_pick_valid;
    logic [CCU_ARB_IDX_WIDTH-1:0]   w_pick_idx;
    logic                           r_we;
    procyon_addr_t                  r_addr;
    procyon_cacheline_t             r_wdata;
    procyon_cacheline_t             r_req_data;
    logic                           r_biu_en;
    logic [CCU_ARB_DEPTH-1:0]       r_req_done;
    logic                           w_biu_en_next;
    logic [CCU_ARB_DEPTH-1:0]       w_req_done_next;

    function automatic logic [CCU_ARB_DEPTH-1:0] idx_to_onehot(input logic [CCU_ARB_IDX_WIDTH-1:0] idx);
        logic [CCU_ARB_DEPTH-1:0] oh;
        oh      = {CCU_ARB_DEPTH{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    rr_picker #(
        .CCU_ARB_DEPTH    (CCU_ARB_DEPTH),
        .CCU_ARB_IDX_WIDTH(CCU_ARB_IDX_WIDTH)
    ) u_rr_picker (
        .i_req  (i_req_en),
        .i_ptr  (r_rr_ptr),
        .o_valid(w_pick_valid),
        .o_idx  (w_pick_idx)
    );

    // After a grant completes, the requester just served drops to lowest priority.
    assign w_ptr_next = (r_grant_idx == CCU_ARB_IDX_WIDTH'(CCU_ARB_DEPTH - 1))
                      ? {CCU_ARB_IDX_WIDTH{1'b0}}
                      : r_grant_idx + CCU_ARB_IDX_WIDTH'(1);

    // State register plus the registered BIU enable and done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_biu_en   <= 1'b0;
            r_req_done <= {CCU_ARB_DEPTH{1'b0}};
        end else begin
            r_state    <= w_state_next;
            r_biu_en   <= w_biu_en_next;
            r_req_done <= w_req_done_next;
        end
    end

    // Next state: grant from IDLE, hold BUSY until the BIU completes, one DRAIN cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) w_state_next = BUSY;
                else              w_state_next = IDLE;
            end
            BUSY: begin
                if (i_biu_done) w_state_next = DRAIN;
                else            w_state_next = BUSY;
            end
            DRAIN:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they leave flops aligned with the state.
    always_comb begin
        w_biu_en_next = (w_state_next == BUSY);
        if (w_state_next == DRAIN) begin
            w_req_done_next = idx_to_onehot(r_grant_idx);
        end else begin
            w_req_done_next = {CCU_ARB_DEPTH{1'b0}};
        end
    end

    // Command latch at grant time, read-data capture and pointer advance on completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr    <= {CCU_ARB_IDX_WIDTH{1'b0}};
            r_grant_idx <= {CCU_ARB_IDX_WIDTH{1'b0}};
            r_we        <= 1'b0;
            r_addr      <= {PROCYON_ADDR_WIDTH{1'b0}};
            r_wdata     <= {PROCYON_CACHELINE_WIDTH{1'b0}};
            r_req_data  <= {PROCYON_CACHELINE_WIDTH{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant_idx <= w_pick_idx;
                        r_we        <= i_req_we[w_pick_idx];
                        r_addr      <= i_req_addr[w_pick_idx];
                        r_wdata     <= i_req_data[w_pick_idx];
                    end
                end
                BUSY: begin
                    if (i_biu_done) begin
                        if (!r_we) begin
                            r_req_data <= i_biu_data;
                        end
                        r_rr_ptr <= w_ptr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_biu_en   = r_biu_en;
    assign o_biu_we   = r_we;
    assign o_biu_addr = r_addr;
    assign o_biu_data = r_wdata;
    assign o_req_data = r_req_data;
    assign o_req_done = r_req_done;

    ccu_arb_chk #(
        .CCU_ARB_DEPTH    (CCU_ARB_DEPTH),
        .CCU_ARB_IDX_WIDTH(CCU_ARB_IDX_WIDTH)
    ) u_chk (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_state    (r_state),
        .i_grant_idx(r_grant_idx),
        .i_req_en   (i_req_en),
        .i_req_done (r_req_done),
        .i_biu_en   (r_biu_en),
        .i_biu_busy (i_biu_busy),
        .i_biu_done (i_biu_done)
    );

endmodule
